apb_cmd_master: RTL and testbench

- Simple APB bus controller that drives the per-slot APB slave models in the CoreABC test environment.
- Accepts one command at a time on a valid/ready interface and sequences the APB SETUP and ACCESS phases.
- Decodes a slot number to a one-hot PSEL, waits on PREADY with a timeout, and returns read data and status on a valid/ready response interface.

---
 rtl/apb_cmd_master.sv | 174 +++++++++++++++++
 tb/tb_apb_cmd_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB requester.
// Takes a command on a valid/ready port, runs the SETUP and ACCESS phases
// towards one slot, and returns read data and status on a valid/ready port.
// Abandons a transfer whose PREADY stays low for TIMEOUT ACCESS cycles.
module apb_cmd_master #(
    parameter int unsigned AWIDTH  = 8,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned NSLOTS  = 4,
    parameter int unsigned SWIDTH  = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // command port
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [SWIDTH-1:0] CMD_SLOT,
    input  logic [AWIDTH-1:0] CMD_ADDR,
    input  logic [DWIDTH-1:0] CMD_WDATA,
    // response port
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DWIDTH-1:0] RSP_RDATA,
    output logic              RSP_ERROR,
    // APB requester
    output logic [NSLOTS-1:0] PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int unsigned CWIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [CWIDTH-1:0]   cnt_q,       cnt_d;
    logic [NSLOTS-1:0]   psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                pwrite_q,    pwrite_d;
    logic [AWIDTH-1:0]   paddr_q,     paddr_d;
    logic [DWIDTH-1:0]   pwdata_q,    pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_error_q, rsp_error_d;

    logic                slot_bad;

    // Slot indices at or beyond NSLOTS have no slave behind them.
    assign slot_bad = (32'(CMD_SLOT) >= NSLOTS);

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    if (slot_bad) begin
                        // Illegal slot: answer with an error, leave the bus alone.
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = ST_RESP;
                    end else begin
                        psel_d    = NSLOTS'(1) << CMD_SLOT;
                        penable_d = 1'b0;
                        pwrite_d  = CMD_WRITE;
                        paddr_d   = CMD_ADDR;
                        pwdata_d  = CMD_WDATA;
                        state_d   = ST_SETUP;
                    end
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (PREADY) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // Slave never answered: end the transfer with an error.
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CWIDTH'(1);
                end
            end

            ST_RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Only the command handshake is a direct state decode.
    assign CMD_READY = (state_q == ST_IDLE);

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERROR = rsp_error_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with NSLOTS=3 and a memory-backed slave model.
module tb_apb_cmd_master;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned NS = 3;
    localparam int unsigned SW = 2;
    localparam int unsigned TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic          CMD_WRITE;
    logic [SW-1:0] CMD_SLOT;
    logic [AW-1:0] CMD_ADDR;
    logic [DW-1:0] CMD_WDATA;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [DW-1:0] RSP_RDATA;
    logic          RSP_ERROR;
    logic [NS-1:0] PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    int n_checks = 0;
    int n_pass   = 0;

    // slave model controls and state
    int        wait_n    = 0;
    bit        stuck     = 1'b0;
    int        acc_cnt   = 0;
    int        proto_err = 0;
    logic [7:0] mem [0:767] = '{default: 8'h00};

    logic [NS-1:0] prev_psel    = '0;
    logic          prev_pen     = 1'b0;
    logic [AW-1:0] prev_paddr   = '0;
    logic          prev_pwrite  = 1'b0;
    logic [DW-1:0] prev_pwdata  = '0;

    apb_cmd_master #(
        .AWIDTH (AW),
        .DWIDTH (DW),
        .NSLOTS (NS),
        .SWIDTH (SW),
        .TIMEOUT(TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_WRITE(CMD_WRITE),
        .CMD_SLOT (CMD_SLOT),
        .CMD_ADDR (CMD_ADDR),
        .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY),
        .RSP_RDATA(RSP_RDATA),
        .RSP_ERROR(RSP_ERROR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    function automatic int sel_idx(input logic [NS-1:0] sel);
        int r = 0;
        for (int i = 0; i < int'(NS); i++) if (sel[i]) r = i;
        return r;
    endfunction

    // slave model: per-slot byte memory, programmable wait states
    assign PRDATA = mem[sel_idx(PSEL) * 256 + int'(PADDR)];
    assign PREADY = !stuck && (acc_cnt >= wait_n);

    always @(posedge PCLK) begin
        if (PENABLE) acc_cnt <= acc_cnt + 1;
        else         acc_cnt <= 0;
        if (PSEL != '0 && PENABLE && PREADY && PWRITE)
            mem[sel_idx(PSEL) * 256 + int'(PADDR)] <= PWDATA;
    end

    // protocol monitor sampled on the falling edge
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if ($countones(PSEL) > 1) proto_err <= proto_err + 1;
            if (PENABLE && PSEL == '0) proto_err <= proto_err + 1;
            if (PENABLE && (PSEL != prev_psel || PADDR != prev_paddr ||
                            PWRITE != prev_pwrite || PWDATA != prev_pwdata))
                proto_err <= proto_err + 1;
        end
        prev_psel   <= PSEL;
        prev_pen    <= PENABLE;
        prev_paddr  <= PADDR;
        prev_pwrite <= PWRITE;
        prev_pwdata <= PWDATA;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Issue one command, follow it to the response and retire it.
    task automatic run_cmd(input string tag, input logic wr, input logic [SW-1:0] slot,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input int exp_ps, input int exp_pe,
                           input int hold);
        int lat, ps, pe;
        bit bad, hold_bad;
        logic [NS-1:0] exp_sel;
        exp_sel = NS'(1) << slot;
        check({tag, ":cmd_ready"}, 32'(CMD_READY), 32'd1);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_SLOT  = slot;
        CMD_ADDR  = addr;
        CMD_WDATA = wdata;
        step();
        CMD_VALID = 1'b0;
        CMD_ADDR  = ~addr;
        CMD_WDATA = ~wdata;
        CMD_WRITE = ~wr;
        lat = 1; ps = 0; pe = 0; bad = 1'b0;
        while (!RSP_VALID && lat < 64) begin
            if (PSEL != '0) begin
                ps++;
                if (PSEL != exp_sel || PADDR != addr || PWRITE != wr || (wr && PWDATA != wdata))
                    bad = 1'b1;
            end
            if (PENABLE) pe++;
            step();
            lat++;
        end
        check({tag, ":rsp_valid"}, 32'(RSP_VALID), 32'd1);
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ":psel_cycles"}, 32'(ps), 32'(exp_ps));
        check({tag, ":penable_cycles"}, 32'(pe), 32'(exp_pe));
        check({tag, ":bus_fields"}, 32'(bad), 32'd0);
        check({tag, ":bus_idle"}, {30'd0, PSEL != '0, PENABLE}, 32'd0);
        check({tag, ":rsp_error"}, 32'(RSP_ERROR), 32'(exp_err));
        check({tag, ":rsp_rdata"}, 32'(RSP_RDATA), 32'(exp_rdata));
        if (hold > 0) begin
            hold_bad = 1'b0;
            CMD_VALID = 1'b1;
            CMD_SLOT  = 2'd0;
            for (int i = 0; i < hold; i++) begin
                step();
                if (CMD_READY || !RSP_VALID || RSP_RDATA != exp_rdata ||
                    RSP_ERROR != exp_err || PSEL != '0 || PENABLE)
                    hold_bad = 1'b1;
            end
            CMD_VALID = 1'b0;
            check({tag, ":hold_stable"}, 32'(hold_bad), 32'd0);
        end
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        check({tag, ":retire"}, {30'd0, RSP_VALID, CMD_READY}, 32'd1);
    endtask

    initial begin
        PRESET    = 1'b1;
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_SLOT  = '0;
        CMD_ADDR  = '0;
        CMD_WDATA = '0;
        RSP_READY = 1'b0;
        step();
        step();
        check("reset_outs", {1'b0, PSEL, PENABLE, PWRITE, PADDR, PWDATA, RSP_VALID, RSP_ERROR, RSP_RDATA}, 32'd0);
        check("reset_cmd_ready", 32'(CMD_READY), 32'd1);
        PRESET = 1'b0;
        step();

        run_cmd("wr_s1",     1'b1, 2'd1, 8'h12, 8'hA5, 8'h00, 1'b0, 3, 2, 1, 0);
        run_cmd("rd_s1",     1'b0, 2'd1, 8'h12, 8'h00, 8'hA5, 1'b0, 3, 2, 1, 0);
        wait_n = 3;
        run_cmd("rd_wait3",  1'b0, 2'd1, 8'h12, 8'h00, 8'hA5, 1'b0, 6, 5, 4, 0);
        wait_n = 0;
        stuck  = 1'b1;
        run_cmd("rd_timeout", 1'b0, 2'd1, 8'h12, 8'h00, 8'h00, 1'b1, 18, 17, 16, 0);
        stuck  = 1'b0;
        run_cmd("bad_slot",  1'b1, 2'd3, 8'h40, 8'h77, 8'h00, 1'b1, 1, 0, 0, 0);
        run_cmd("wr_s2_hold", 1'b1, 2'd2, 8'h34, 8'h5A, 8'h00, 1'b0, 3, 2, 1, 5);
        run_cmd("rd_s2_hold", 1'b0, 2'd2, 8'h34, 8'h00, 8'h5A, 1'b0, 3, 2, 1, 5);
        run_cmd("rd_s0",     1'b0, 2'd0, 8'h12, 8'h00, 8'h00, 1'b0, 3, 2, 1, 0);

        // reset during ACCESS of a stalled read
        stuck     = 1'b1;
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b0;
        CMD_SLOT  = 2'd0;
        CMD_ADDR  = 8'h77;
        CMD_WDATA = 8'h3C;
        step();
        CMD_VALID = 1'b0;
        step();
        check("mid_access", {30'd0, PENABLE, PSEL[0]}, 32'd3);
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        stuck  = 1'b0;
        check("mid_reset_outs", {1'b0, PSEL, PENABLE, PWRITE, PADDR, PWDATA, RSP_VALID, RSP_ERROR, RSP_RDATA}, 32'd0);
        check("mid_reset_cmd_ready", 32'(CMD_READY), 32'd1);
        begin
            bit saw_rsp = 1'b0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (RSP_VALID || PSEL != '0) saw_rsp = 1'b1;
            end
            check("mid_reset_no_rsp", 32'(saw_rsp), 32'd0);
        end

        run_cmd("rd_after_rst", 1'b0, 2'd1, 8'h12, 8'h00, 8'hA5, 1'b0, 3, 2, 1, 0);
        step();
        check("protocol_errors", 32'(proto_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
